// File: rtl/fft_pkg.sv
// Shared types and width constants for the radix-2 DIT FFT butterfly scheduler.
package fft_pkg;

    localparam int LOG2N_DEFAULT = 4;
    localparam int LOG2N_MIN     = 2;
    localparam int LOG2N_MAX     = 10;
    localparam int STALL_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_WB,
        ST_DONE
    } fsm_state_e;

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational operand-address and twiddle-index generator for one butterfly
// (stage s, butterfly k) of an in-place radix-2 DIT FFT.
module fft_bfly_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT
) (
    input  logic [$clog2(LOG2N)-1:0] stage,
    input  logic [LOG2N-2:0]         k,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx
);

    localparam int SW = $clog2(LOG2N);
    localparam int KW = LOG2N - 1;
    localparam logic [SW:0] TW_TOP = (SW + 1)'(LOG2N - 1);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;

    // Group base is (k >> s) << (s + 1); done as two shifts so the shift
    // amount never needs a wider stage field.
    always_comb begin
        k_ext  = {1'b0, k};
        half   = LOG2N'(1) << stage;
        pos    = k_ext & (half - LOG2N'(1));
        addr_a = (((k_ext >> stage) << stage) << 1) | pos;
        addr_b = addr_a + half;
        tw_idx = KW'(pos << (TW_TOP - {1'b0, stage}));
    end

endmodule

// File: rtl/fft_bfly_sched.sv
// Radix-2 DIT FFT butterfly scheduler: issues operand descriptors stage by stage
// and waits for all write-backs before the next stage. Optional stall_cnt output
// is enabled by defining FFT_BFLY_SCHED_STATS_EN.
module fft_bfly_sched
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     real_mode,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic                     complx_control,
    input  logic                     wb_ack,
    output logic                     busy,
    output logic                     done
`ifdef FFT_BFLY_SCHED_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0]   stall_cnt
`endif
);

    localparam int SW = $clog2(LOG2N);
    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0]    K_LAST     = {KW{1'b1}};
    localparam logic [LOG2N-1:0] HALF_N     = LOG2N'(1) << KW;
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);

    fsm_state_e       state_q, state_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [KW-1:0]    k_q, k_d;
    logic [LOG2N-1:0] ack_q, ack_d;
    logic             cplx_q, cplx_d;

    logic [LOG2N-1:0] gen_a, gen_b;
    logic [KW-1:0]    gen_tw;

    fft_bfly_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .stage  (stage_q),
        .k      (k_q),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        stage_d  = stage_q;
        k_d      = k_q;
        ack_d    = ack_q;
        cplx_d   = cplx_q;
        op_valid = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;

        // Write-backs count only while a stage is in flight, saturating at N/2.
        if (wb_ack && (ack_q != HALF_N) &&
            ((state_q == ST_ISSUE) || (state_q == ST_WAIT_WB))) begin
            ack_d = ack_q + LOG2N'(1);
        end

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_ISSUE;
                    stage_d = '0;
                    k_d     = '0;
                    ack_d   = '0;
                    cplx_d  = ~real_mode;
                end
            end
            ST_ISSUE: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = ST_WAIT_WB;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_WAIT_WB: begin
                if (ack_q == HALF_N) begin
                    ack_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + SW'(1);
                        cplx_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together on the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            ack_q   <= '0;
            cplx_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            ack_q   <= ack_d;
            cplx_q  <= cplx_d;
        end
    end

    // Addresses read as zero whenever no descriptor is on offer.
    assign addr_a         = op_valid ? gen_a  : '0;
    assign addr_b         = op_valid ? gen_b  : '0;
    assign tw_idx         = op_valid ? gen_tw : '0;
    assign stage          = stage_q;
    assign complx_control = cplx_q;

`ifdef FFT_BFLY_SCHED_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_d = '0;
        end else if (op_valid && !op_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Self-checking bench for fft_bfly_sched (LOG2N=3): directed scenarios plus
// randomized handshake/write-back timing against a pair-enumeration model.
module tb_fft_bfly_sched;

    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int HALF  = 4;
    localparam int NBF   = 12;
    localparam int BIG   = 1000000000;

    logic       clk = 1'b0;
    logic       rst_n, start, real_mode, op_ready, wb_ack;
    logic       op_valid, complx_control, busy, done;
    logic [2:0] addr_a, addr_b;
    logic [1:0] tw_idx, stage;
`ifdef FFT_BFLY_SCHED_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    bit running = 0;
    int hs_in_run = 0, ack_in_run = 0, stalls_in_run = 0;
    int neg_cyc = 0, hs_total = 0, acks_sent = 0, dones = 0;
    int full_cyc [LOG2N];
    int exp_q [$];
    bit last_stall = 0;
    int last_desc = 0;
    bit log_en = 0;
    int log_d [NBF];

    bit ack_hold = 0, ack_fast = 1, rdy_rand = 0, rdy_force = 1;

    int lit_a  [NBF] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b  [NBF] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw [NBF] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int lit_cx [NBF] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

    fft_bfly_sched #(.LOG2N(LOG2N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .real_mode      (real_mode),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .addr_a         (addr_a),
        .addr_b         (addr_b),
        .tw_idx         (tw_idx),
        .stage          (stage),
        .complx_control (complx_control),
        .wb_ack         (wb_ack),
        .busy           (busy),
        .done           (done)
`ifdef FFT_BFLY_SCHED_STATS_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pk(input int st, input int a, input int b, input int tw, input int cx);
        return (((st * 16 + a) * 16 + b) * 16 + tw) * 2 + cx;
    endfunction

    // Every stage pairs each address whose bit s is clear with its partner
    // 2^s above it, in ascending order; twiddle is the in-group offset scaled to N/2.
    function automatic void build_exp(input int rm);
        int h;
        exp_q.delete();
        for (int s = 0; s < LOG2N; s++) begin
            h = 1 << s;
            for (int a = 0; a < N; a++) begin
                if (((a >> s) & 1) == 0)
                    exp_q.push_back(pk(s, a, a + h, (a % h) * (HALF / h), (s == 0) ? 1 - rm : 1));
            end
        end
    endfunction

    always @(negedge clk) begin
        int cur, st;
        if (!rst_n) begin
            running    = 0;
            last_stall = 0;
            exp_q.delete();
        end else begin
            neg_cyc++;
            cur = pk(int'(stage), int'(addr_a), int'(addr_b), int'(tw_idx), int'(complx_control));
            check("busy", int'(busy), int'(running));
            if (!running || hs_in_run >= NBF) begin
                check("op_valid_idle", int'(op_valid), 0);
            end else if (op_valid) begin
                st = hs_in_run / HALF;
                if (st > 0)
                    check("issue_after_acks", int'(neg_cyc >= full_cyc[st-1] + 2), 1);
                if (last_stall)
                    check("stall_stable", cur, last_desc);
                if (op_ready) begin
                    check("descriptor", cur, exp_q.pop_front());
                    if (log_en) log_d[hs_in_run] = cur;
                    hs_in_run++;
                    hs_total++;
                end else begin
                    stalls_in_run++;
                end
            end
            last_stall = op_valid && !op_ready;
            last_desc  = cur;
            if (wb_ack && running) begin
                ack_in_run++;
                if ((ack_in_run % HALF) == 0 && ack_in_run <= NBF)
                    full_cyc[ack_in_run / HALF - 1] = neg_cyc;
            end
            if (done) begin
                check("done_while_running", int'(running), 1);
                check("done_handshakes", hs_in_run, NBF);
                check("done_acks", ack_in_run, NBF);
                dones++;
                running = 0;
            end else if (start && !running) begin
                running       = 1;
                hs_in_run     = 0;
                ack_in_run    = 0;
                stalls_in_run = 0;
                foreach (full_cyc[i]) full_cyc[i] = BIG;
                build_exp(int'(real_mode));
            end
        end
    end

    // NOTE: bench inputs change with blocking assignments #1 after the edge,
    // so the DUT never sees them race the sampling edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            acks_sent = hs_total;
            wb_ack    = 1'b0;
        end else if (hs_total > acks_sent && !ack_hold &&
                     (ack_fast || $urandom_range(0, 2) != 0)) begin
            wb_ack = 1'b1;
            acks_sent++;
        end else begin
            wb_ack = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        op_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_op_valid"}, int'(op_valid), 0);
        check({tag, "_addr_a"},   int'(addr_a), 0);
        check({tag, "_addr_b"},   int'(addr_b), 0);
        check({tag, "_tw_idx"},   int'(tw_idx), 0);
        check({tag, "_stage"},    int'(stage), 0);
        check({tag, "_complx"},   int'(complx_control), 0);
        check({tag, "_busy"},     int'(busy), 0);
        check({tag, "_done"},     int'(done), 0);
    endtask

    task automatic do_start(input logic rm);
        @(posedge clk); #1;
        real_mode = rm;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = dones;
        int n  = 0;
        while (dones == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_count", dones - d0, 1);
        repeat (3) @(posedge clk);
        check("single_done", dones - d0, 1);
    endtask

    task automatic wait_hs(input int want, input int budget);
        int n = 0;
        while (hs_in_run < want && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("handshakes_reached", int'(hs_in_run >= want), 1);
    endtask

    initial begin
        int d0, n;
        rst_n = 1'b0; start = 1'b0; real_mode = 1'b0;
        wb_ack = 1'b0; op_ready = 1'b0;
        #12;
        check_outputs_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Fully directed run pinned against the hand-derived descriptor table.
        log_en = 1;
        do_start(1'b1);
        wait_done(200);
        log_en = 0;
        for (int i = 0; i < NBF; i++)
            check("literal_desc", log_d[i], pk(i / HALF, lit_a[i], lit_b[i], lit_tw[i], lit_cx[i]));

        // Five-cycle op_ready stall in the middle of stage 0.
        do_start(1'b0);
        wait_hs(2, 50);
        @(negedge clk); rdy_force = 0;
        repeat (5) @(negedge clk);
        rdy_force = 1;
        wait_done(200);
        check("stall_cycles", stalls_in_run, 5);
`ifdef FFT_BFLY_SCHED_STATS_EN
        check("stall_cnt", int'(stall_cnt), 5);
`endif

        // Write-backs withheld after stage 0 has issued.
        ack_hold = 1;
        do_start(1'b1);
        wait_hs(4, 50);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("wait_wb_valid", int'(op_valid), 0);
            check("wait_wb_stage", int'(stage), 0);
            check("wait_wb_busy", int'(busy), 1);
        end
        ack_hold = 0;
        wait_done(200);

        // start held high through ISSUE, WAIT_WB and the DONE cycle.
        rdy_rand = 1; ack_fast = 0;
        d0 = dones;
        do_start(1'b0);
        wait_hs(1, 50);
        @(posedge clk); #1 start = 1'b1;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_with_start_held", int'(done), 1);
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("one_done_per_start", dones - d0, 1);
        check("idle_after_held_start", int'(busy), 0);

        // Reset while stage 1 is in progress, then a fresh run.
        do_start(1'b1);
        wait_hs(5, 200);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("midrun_reset");
        d0 = dones;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("no_done_after_reset", dones - d0, 0);
        do_start(1'b0);
        wait_done(800);

        // Randomized handshake and write-back timing.
        for (int r = 0; r < 6; r++) begin
            ack_fast = 1'($urandom_range(0, 1));
            do_start(1'($urandom_range(0, 1)));
            wait_done(800);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
